// File: rtl/fxp_requant.sv
// Fixed-point requantizer: aligns a signed word from a dynamic (QI, QF) format
// to a requested target format, one bit per cycle, saturating or rounding.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module fxp_requant #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic [3:0]           in_qi,
  input  logic [3:0]           in_qf,
  input  logic [3:0]           tgt_qi,
  input  logic [3:0]           tgt_qf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [3:0]           out_qi,
  output logic [3:0]           out_qf,
  output logic                 out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r;
  logic [WORD_SIZE-1:0] data_r;
  logic [3:0]           cnt_r;
  logic                 left_r;
  logic                 sat_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [3:0]           tgt_qi_r;
  logic [3:0]           tgt_qf_r;

  logic [4:0]           d_s;
  logic [3:0]           abs_d_s;
  logic [WORD_SIZE-1:0] shr_s;
  logic [WORD_SIZE-1:0] round_s;
  logic                 left_ovf_s;
  logic                 rnd_ovf_s;
  logic                 unused_s;

  localparam logic [WORD_SIZE-1:0] MAX_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};

  function automatic logic [WORD_SIZE-1:0] sat_value(input logic sign);
    sat_value = {sign, {(WORD_SIZE-1){~sign}}};
  endfunction

  // The source integer-bit count carries no arithmetic meaning here.
  assign unused_s = ^in_qi;

  // Shift distance and per-step alignment/rounding candidates.
  always_comb begin
    d_s        = {1'b0, tgt_qf} - {1'b0, in_qf};
    abs_d_s    = 4'd0;
    if (d_s[4]) begin
      abs_d_s = 4'(5'd0 - d_s);
    end else begin
      abs_d_s = d_s[3:0];
    end
    shr_s      = {data_r[WORD_SIZE-1], data_r[WORD_SIZE-1:1]};
    // data_r[0] is the guard bit leaving on this step; adding it rounds half-up.
    round_s    = shr_s + {{(WORD_SIZE-1){1'b0}}, data_r[0]};
    left_ovf_s = data_r[WORD_SIZE-1] ^ data_r[WORD_SIZE-2];
    rnd_ovf_s  = data_r[0] && (shr_s == MAX_POS);
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= '0;
      cnt_r       <= 4'd0;
      left_r      <= 1'b0;
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      tgt_qi_r    <= 4'd0;
      tgt_qf_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            data_r     <= in_data;
            tgt_qi_r   <= tgt_qi;
            tgt_qf_r   <= tgt_qf;
            cnt_r      <= abs_d_s;
            left_r     <= ~d_s[4];
            sat_r      <= 1'b0;
            in_ready_r <= 1'b0;
            if (d_s == 5'd0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (left_r) begin
            if (left_ovf_s) begin
              data_r      <= sat_value(data_r[WORD_SIZE-1]);
              sat_r       <= 1'b1;
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              data_r <= {data_r[WORD_SIZE-2:0], 1'b0};
              cnt_r  <= cnt_r - 4'd1;
              if (cnt_r == 4'd1) begin
                state_r     <= DONE;
                out_valid_r <= 1'b1;
              end
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              if (rnd_ovf_s) begin
                data_r <= MAX_POS;
                sat_r  <= 1'b1;
              end else begin
                data_r <= round_s;
              end
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              data_r <= shr_s;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = data_r;
  assign out_qi    = tgt_qi_r;
  assign out_qf    = tgt_qf_r;
  assign out_sat   = sat_r;

endmodule

// File: tb/tb_fxp_requant.sv
// Directed self-checking bench for fxp_requant: alignment, saturation,
// rounding, backpressure and reset abort.
module tb_fxp_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_qi;
  logic [3:0]  in_qf;
  logic [3:0]  tgt_qi;
  logic [3:0]  tgt_qf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_qi;
  logic [3:0]  out_qf;
  logic        out_sat;

  int total = 0;
  int bad   = 0;

  fxp_requant #(.WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_qi(in_qi), .in_qf(in_qf), .tgt_qi(tgt_qi), .tgt_qf(tgt_qf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_qi(out_qi), .out_qf(out_qf), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present one word, let it be accepted, and return the cycle (relative to
  // the accept cycle A) in which out_valid is first seen high; 40 = timeout.
  task automatic start_conv(input logic [15:0] d, input logic [3:0] qi,
                            input logic [3:0] qf, input logic [3:0] tqi,
                            input logic [3:0] tqf, output int lat);
    in_data  = d;
    in_qi    = qi;
    in_qf    = qf;
    tgt_qi   = tqi;
    tgt_qf   = tqf;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    total++; if (out_qi !== 4'd0 || out_qf !== 4'd0) begin bad++; $display("FAIL reset_out_fmt got=%0d.%0d exp=0.0", out_qi, out_qf); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
  endtask

  task automatic test_left_shift();
    int lat;
    start_conv(16'h0180, 4'd8, 4'd8, 4'd4, 4'd12, lat);
    total++; if (lat != 5) begin bad++; $display("FAIL left_latency got=%0d exp=5", lat); end
    total++; if (out_data !== 16'h1800) begin bad++; $display("FAIL left_data got=%h exp=1800", out_data); end
    total++; if (out_qi !== 4'd4 || out_qf !== 4'd12) begin bad++; $display("FAIL left_fmt got=%0d.%0d exp=4.12", out_qi, out_qf); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL left_sat got=%b exp=0", out_sat); end
    retire();
  endtask

  task automatic test_left_sat();
    int lat;
    start_conv(16'h4000, 4'd8, 4'd8, 4'd4, 4'd12, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL satpos_latency got=%0d exp=2", lat); end
    total++; if (out_data !== 16'h7FFF || out_sat !== 1'b1) begin bad++; $display("FAIL satpos_data got=%h/%b exp=7fff/1", out_data, out_sat); end
    retire();
    // 0xC000 shifts once cleanly to 0x8000, then overflows on the second step.
    start_conv(16'hC000, 4'd8, 4'd8, 4'd4, 4'd12, lat);
    total++; if (lat != 3) begin bad++; $display("FAIL satneg_latency got=%0d exp=3", lat); end
    total++; if (out_data !== 16'h8000 || out_sat !== 1'b1) begin bad++; $display("FAIL satneg_data got=%h/%b exp=8000/1", out_data, out_sat); end
    retire();
  endtask

  task automatic test_right_round();
    logic [15:0] vin [3];
    logic [15:0] vexp [3];
    int lat;
    vin[0] = 16'h0018; vexp[0] = 16'h0002;
    vin[1] = 16'hFFE8; vexp[1] = 16'hFFFF;
    vin[2] = 16'h0017; vexp[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      start_conv(vin[i], 4'd8, 4'd8, 4'd12, 4'd4, lat);
      total++; if (lat != 5) begin bad++; $display("FAIL right_latency[%0d] got=%0d exp=5", i, lat); end
      total++; if (out_data !== vexp[i] || out_sat !== 1'b0) begin bad++; $display("FAIL right_data[%0d] got=%h/%b exp=%h/0", i, out_data, out_sat, vexp[i]); end
      retire();
    end
  endtask

  task automatic test_zero_backpressure();
    int lat;
    out_ready = 1'b0;
    start_conv(16'h1234, 4'd8, 4'd8, 4'd8, 4'd8, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold[%0d] got valid=%b data=%h in_ready=%b exp 1/1234/0", i, out_valid, out_data, in_ready);
      end
      @(posedge clk);
      #1;
    end
    retire();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL after_retire got valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_round_ovf();
    int lat;
    // Q1.15 -> Q2.14, one right shift of max positive.
    start_conv(16'h7FFF, 4'd1, 4'd15, 4'd2, 4'd14, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL rndovf_latency got=%0d exp=2", lat); end
    total++; if (out_data !== 16'h4000 || out_sat !== 1'b0) begin bad++; $display("FAIL rndovf_data got=%h/%b exp=4000/0", out_data, out_sat); end
    retire();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    in_data  = 16'h0100;
    in_qi    = 4'd8;
    in_qf    = 4'd0;
    tgt_qi   = 4'd0;
    tgt_qf   = 4'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sat !== 1'b0) begin bad++; $display("FAIL midrst_state got valid=%b in_ready=%b sat=%b exp 0/1/0", out_valid, in_ready, out_sat); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_output got=%0d valid cycles exp=0", seen); end
    start_conv(16'h0001, 4'd8, 4'd0, 4'd0, 4'd8, lat);
    total++; if (lat != 9) begin bad++; $display("FAIL postrst_latency got=%0d exp=9", lat); end
    total++; if (out_data !== 16'h0100 || out_sat !== 1'b0) begin bad++; $display("FAIL postrst_data got=%h/%b exp=0100/0", out_data, out_sat); end
    retire();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_qi     = 4'd0;
    in_qf     = 4'd0;
    tgt_qi    = 4'd0;
    tgt_qf    = 4'd0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_left_shift();
    test_left_sat();
    test_right_round();
    test_zero_backpressure();
    test_round_ovf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
